// File: rtl/sync_down_timer_pkg.sv
// Shared types and defaults for the loadable down timer.
package sync_down_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } timer_state_t;

endpackage

// File: rtl/down_counter_core.sv
// Count and reload registers; the decrement saturates at zero.
module down_counter_core
    import sync_down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             reload,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] reload_reg,
    output logic             is_one
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q          <= '0;
            reload_reg <= '0;
        end else if (load) begin
            q          <= load_val;
            reload_reg <= load_val;
        end else if (reload) begin
            q <= reload_reg;
        end else if (dec && (q != '0)) begin
            q <= q - WIDTH'(1);
        end
    end

    assign is_one = (q == WIDTH'(1));

endmodule

// File: rtl/sync_down_timer.sv
// Loadable down timer: one-shot or periodic, with a terminal-count pulse.
module sync_down_timer
    import sync_down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    timer_state_t     state, next_state;
    logic             next_tc;
    logic             c_load, c_reload, c_dec;
    logic             is_one;
    logic [WIDTH-1:0] reload_reg;

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (c_load),
        .load_val   (load_val),
        .reload     (c_reload),
        .dec        (c_dec),
        .q          (q),
        .reload_reg (reload_reg),
        .is_one     (is_one)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            tc    <= next_tc;
            busy  <= (next_state == ST_RUN);
            done  <= (next_state == ST_DONE);
        end
    end

    // Priority: load > stop > start > count.
    always_comb begin
        next_state = state;
        next_tc    = 1'b0;
        c_load     = 1'b0;
        c_reload   = 1'b0;
        c_dec      = 1'b0;
        if (load) begin
            c_load     = 1'b1;
            next_state = ST_IDLE;
        end else if (stop) begin
            if (state == ST_RUN)
                next_state = ST_IDLE;
        end else if (start && (state != ST_RUN)) begin
            if (q == '0) begin
                next_state = ST_DONE;
                next_tc    = 1'b1;
            end else begin
                next_state = ST_RUN;
            end
        end else if (state == ST_RUN) begin
            if (q == '0) begin
                // Unreachable in normal use; park in DONE rather than wrap.
                next_state = ST_DONE;
            end else if (en) begin
                if (is_one) begin
                    next_tc = 1'b1;
                    if (auto_reload) begin
                        c_reload = 1'b1;
                    end else begin
                        c_dec      = 1'b1;
                        next_state = ST_DONE;
                    end
                end else begin
                    c_dec = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_down_timer.sv
// Directed bench for sync_down_timer with a per-cycle reference model.
module tb_sync_down_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         en = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] q;
    logic         tc, busy, done;

    int checks = 0;
    int errors = 0;

    sync_down_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = running, 2 = expired.
    int m_q, m_rel, m_st;
    bit m_tc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q <= 0; m_rel <= 0; m_st <= 0; m_tc <= 1'b0;
        end else begin
            m_tc <= 1'b0;
            if (load) begin
                m_q <= int'(load_val); m_rel <= int'(load_val); m_st <= 0;
            end else if (stop) begin
                if (m_st == 1) m_st <= 0;
            end else if (start && m_st != 1) begin
                if (m_q == 0) begin m_st <= 2; m_tc <= 1'b1; end
                else m_st <= 1;
            end else if (m_st == 1 && en) begin
                if (m_q == 1) begin
                    m_tc <= 1'b1;
                    if (auto_reload) m_q <= m_rel;
                    else begin m_q <= 0; m_st <= 2; end
                end else if (m_q > 1) begin
                    m_q <= m_q - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_q", int'(q), m_q);
            chk("model_tc", int'(tc), int'(m_tc));
            chk("model_busy", int'(busy), int'(m_st == 1));
            chk("model_done", int'(done), int'(m_st == 2));
        end
    end

    // Apply one cycle of inputs; returns at the negedge after the sampling edge.
    task automatic step(input bit l, input int lv, input bit st, input bit sp, input bit e);
        load = l; load_val = W'(lv); start = st; stop = sp; en = e;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int tc_cnt;

    initial begin
        @(negedge clk);
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // One-shot: 3,2,1,0 with tc only on reaching 0
        step(1, 3, 0, 0, 0);  chk("os_load", int'(q), 3);
        step(0, 0, 1, 0, 1);  chk("os_start_q", int'(q), 3); chk("os_busy", int'(busy), 1);
        step(0, 0, 0, 0, 1);  chk("os_q2", int'(q), 2); chk("os_tc2", int'(tc), 0);
        step(0, 0, 0, 0, 1);  chk("os_q1", int'(q), 1);
        step(0, 0, 0, 0, 1);  chk("os_q0", int'(q), 0); chk("os_tc0", int'(tc), 1);
        chk("os_done", int'(done), 1); chk("os_busy_end", int'(busy), 0);
        step(0, 0, 0, 0, 1);  chk("os_tc_after", int'(tc), 0); chk("os_q_hold", int'(q), 0);

        // Auto-reload with en every other cycle: tc every 4 clocks
        auto_reload = 1'b1;
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        tc_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, (i % 2) == 0);
            if (tc) tc_cnt++;
            chk("ar_busy", int'(busy), 1);
        end
        chk("ar_tc_count", tc_cnt, 4);
        // reload value 1 with en held: tc on every tick
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        tc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1);
            if (tc) tc_cnt++;
        end
        chk("ar1_tc_count", tc_cnt, 5);
        auto_reload = 1'b0;

        // Gating and stop/resume
        step(1, 10, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);  chk("gate_hold", int'(q), 6);
        step(0, 0, 0, 1, 1);  chk("stop_q", int'(q), 6); chk("stop_busy", int'(busy), 0);
        step(0, 0, 0, 0, 1);  chk("idle_no_count", int'(q), 6);
        step(0, 0, 1, 0, 1);  chk("resume_busy", int'(busy), 1);
        step(0, 0, 0, 0, 1);  chk("resume_q5", int'(q), 5);
        step(0, 0, 1, 0, 1);  chk("run_start_ignored", int'(q), 4);

        // Priority
        step(1, 7, 1, 0, 1);  chk("ld_start_q", int'(q), 7); chk("ld_start_busy", int'(busy), 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);  chk("stop_start_busy", int'(busy), 0); chk("stop_start_q", int'(q), 7);

        // Zero-length timeout
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1);  chk("z_tc", int'(tc), 1); chk("z_done", int'(done), 1); chk("z_q", int'(q), 0);
        step(0, 0, 0, 0, 1);  chk("z_tc_once", int'(tc), 0);

        // Full-scale count never wraps
        step(1, 255, 0, 0, 0);
        step(0, 0, 1, 0, 0);  chk("max_q", int'(q), 255);
        for (int i = 0; i < 255; i++) step(0, 0, 0, 0, 1);
        chk("max_q0", int'(q), 0); chk("max_done", int'(done), 1);
        step(0, 0, 0, 0, 1);  chk("max_nowrap", int'(q), 0);

        // Async reset mid-run at q=5
        step(1, 8, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("pre_rst_q", int'(q), 5);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_q", int'(q), 0); chk("arst_tc", int'(tc), 0);
        chk("arst_busy", int'(busy), 0); chk("arst_done", int'(done), 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        step(0, 0, 0, 0, 1);  chk("post_rst_idle", int'(busy), 0);
        step(0, 0, 1, 0, 1);  chk("post_rst_zero_start", int'(done), 1);
        step(1, 4, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1);  chk("post_rst_count", int'(q), 3);
        step(0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
